branch_predictor: RTL and testbench

//  Fetch-stage branch target buffer (BTB) with per-entry saturating counters for the pipelined ARM core.

---
 rtl/bp_pkg.sv | 43 ++++
 rtl/sat_counter.sv | 27 ++
 rtl/branch_predictor.sv | 176 +++++++++++++++++
 tb/tb_branch_predictor.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types, widths and helpers for the fetch-stage branch predictor.
package bp_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned CNT_W   = 2;

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  // Word-aligned PCs: bits [1:0] take part in neither index nor tag.
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // Fresh allocations start weakly taken.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1 << (CNT_W - 1));

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef struct packed {
    logic  valid;
    tag_t  tag;
    addr_t target;
    cnt_t  cnt;
  } btb_entry_t;

  // Prediction carried down the pipeline next to the instruction.
  typedef struct packed {
    logic  taken;
    addr_t target;
    addr_t pc;
  } pred_t;

  function automatic idx_t idx_of(input addr_t pc);
    return IDX_W'(pc >> 2);
  endfunction

  function automatic tag_t tag_of(input addr_t pc);
    return TAG_W'(pc >> (IDX_W + 2));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Combinational next value of a saturating up/down counter with parallel load.
module sat_counter #(
  parameter int unsigned CntW = 2
) (
  input  logic [CntW-1:0] cnt_i,
  input  logic            inc_i,
  input  logic            dec_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic [CntW-1:0] cnt_o
);

  localparam logic [CntW-1:0] Max = {CntW{1'b1}};

  // Load wins over inc, inc over dec; the value holds at either rail.
  always_comb begin
    cnt_o = cnt_i;
    if (load_i) begin
      cnt_o = load_val_i;
    end else if (inc_i) begin
      if (cnt_i != Max) cnt_o = cnt_i + CntW'(1);
    end else if (dec_i) begin
      if (cnt_i != '0) cnt_o = cnt_i - CntW'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters: predicts in F, carries the
// prediction through D and E, and checks it against the branch resolved in E.
module branch_predictor
  import bp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PCF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  output logic              PredTakenF,
  output logic [ADDR_W-1:0] PredTargetF,
  input  logic              ValidE,
  input  logic              BranchE,
  input  logic              BranchTakenE,
  input  logic [ADDR_W-1:0] BranchTargetE,
  output logic              MispredictE,
  output logic [ADDR_W-1:0] RedirectPCE
);

  // Table storage; only valid and cnt are reset, tag/target are don't-care while invalid.
  logic  valid_q  [ENTRIES];
  logic  valid_d  [ENTRIES];
  cnt_t  cnt_q    [ENTRIES];
  cnt_t  cnt_d    [ENTRIES];
  tag_t  tag_q    [ENTRIES];
  tag_t  tag_d    [ENTRIES];
  addr_t target_q [ENTRIES];
  addr_t target_d [ENTRIES];

  pred_t fd_q, fd_d;
  pred_t de_q, de_d;

  idx_t  f_idx;
  logic  f_hit;
  idx_t  e_idx;
  tag_t  e_tag;
  logic  e_hit;
  cnt_t  e_cnt;
  cnt_t  cnt_next;

  logic  cnt_inc, cnt_dec, cnt_load;
  logic  we_valid, we_tag, we_target, we_cnt;
  btb_entry_t wr_entry;

  // Fetch lookup: combinational on PCF, always sees pre-update table contents.
  always_comb begin
    f_idx       = idx_of(PCF);
    f_hit       = valid_q[f_idx] && (tag_q[f_idx] == tag_of(PCF));
    PredTakenF  = f_hit && cnt_q[f_idx][CNT_W-1];
    PredTargetF = f_hit ? target_q[f_idx] : '0;
  end

  // Pipeline next-state: F->D holds on stall, clears on flush; D->E clears on flush.
  always_comb begin
    fd_d = fd_q;
    if (!StallD) begin
      if (FlushD) begin
        fd_d = '0;
      end else begin
        fd_d.taken  = PredTakenF;
        fd_d.target = PredTargetF;
        fd_d.pc     = PCF;
      end
    end
    de_d = FlushE ? '0 : fd_q;
  end

  // Pipeline prediction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fd_q <= '0;
      de_q <= '0;
    end else begin
      fd_q <= fd_d;
      de_q <= de_d;
    end
  end

  // E-stage view of the entry the resolving instruction maps to.
  always_comb begin
    e_idx = idx_of(de_q.pc);
    e_tag = tag_of(de_q.pc);
    e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    e_cnt = cnt_q[e_idx];
  end

  sat_counter #(
    .CntW (CNT_W)
  ) u_sat_counter (
    .cnt_i      (e_cnt),
    .inc_i      (cnt_inc),
    .dec_i      (cnt_dec),
    .load_i     (cnt_load),
    .load_val_i (CNT_INIT),
    .cnt_o      (cnt_next)
  );

  // Update decision for the single write port.
  always_comb begin
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    cnt_load  = 1'b0;
    we_valid  = 1'b0;
    we_tag    = 1'b0;
    we_target = 1'b0;
    we_cnt    = 1'b0;
    wr_entry.valid  = 1'b0;
    wr_entry.tag    = e_tag;
    wr_entry.target = BranchTargetE;
    wr_entry.cnt    = cnt_next;
    if (ValidE) begin
      if (BranchE) begin
        if (e_hit) begin
          we_cnt    = 1'b1;
          cnt_inc   = BranchTakenE;
          cnt_dec   = !BranchTakenE;
          we_target = BranchTakenE;
        end else if (BranchTakenE) begin
          // Allocate by overwriting whatever occupied the slot.
          cnt_load       = 1'b1;
          we_valid       = 1'b1;
          wr_entry.valid = 1'b1;
          we_tag         = 1'b1;
          we_target      = 1'b1;
          we_cnt         = 1'b1;
        end
      end else if (e_hit) begin
        // A non-branch hit means the entry is stale or aliased; drop it.
        we_valid = 1'b1;
      end
    end
  end

  // Table next-state: copy all entries, then apply the one write.
  always_comb begin
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (we_valid)  valid_d[e_idx]  = wr_entry.valid;
    if (we_cnt)    cnt_d[e_idx]    = wr_entry.cnt;
    if (we_tag)    tag_d[e_idx]    = wr_entry.tag;
    if (we_target) target_d[e_idx] = wr_entry.target;
  end

  // Valid bits and counters, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tags and targets, no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  // Resolution check and redirect target.
  always_comb begin
    MispredictE = ValidE &&
                  ((BranchE && ((de_q.taken != BranchTakenE) ||
                                (BranchTakenE && (de_q.target != BranchTargetE)))) ||
                   (!BranchE && de_q.taken));
    RedirectPCE = (BranchE && BranchTakenE) ? BranchTargetE : de_q.pc + ADDR_W'(4);
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        StallD, FlushD, FlushE;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        ValidE, BranchE, BranchTakenE;
  logic [31:0] BranchTargetE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;

  localparam logic [31:0] Fill = 32'h0000_2004;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  branch_predictor dut (
    .clk           (clk),
    .reset         (reset),
    .PCF           (PCF),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .FlushE        (FlushE),
    .PredTakenF    (PredTakenF),
    .PredTargetF   (PredTargetF),
    .ValidE        (ValidE),
    .BranchE       (BranchE),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .MispredictE   (MispredictE),
    .RedirectPCE   (RedirectPCE)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_e();
    ValidE        = 1'b0;
    BranchE       = 1'b0;
    BranchTakenE  = 1'b0;
    BranchTargetE = '0;
  endtask

  // Fetch pc, let it flow to E, resolve it there; check F and E outputs.
  task automatic run_instr(input string name, input logic [31:0] pc, input logic br,
                           input logic tk, input logic [31:0] tgt, input logic exp_pt,
                           input logic [31:0] exp_ptgt, input logic exp_misp,
                           input logic [31:0] exp_redir);
    StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
    clear_e();
    PCF = pc;
    #2;
    check_eq({name, ".pred_taken"}, 32'(PredTakenF), 32'(exp_pt));
    check_eq({name, ".pred_target"}, PredTargetF, exp_ptgt);
    tick();
    PCF = Fill;
    tick();
    ValidE = 1'b1; BranchE = br; BranchTakenE = br & tk; BranchTargetE = tgt;
    #2;
    check_eq({name, ".mispredict"}, 32'(MispredictE), 32'(exp_misp));
    check_eq({name, ".redirect"}, RedirectPCE, exp_redir);
    tick();
    clear_e();
  endtask

  initial begin
    reset = 1'b1;
    PCF = 32'h100; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
    clear_e();
    #2;
    check_eq("rst.pred_taken", 32'(PredTakenF), 32'd0);
    check_eq("rst.pred_target", PredTargetF, 32'd0);
    check_eq("rst.mispredict", 32'(MispredictE), 32'd0);
    check_eq("rst.redirect", RedirectPCE, 32'd4);
    tick();
    reset = 1'b0;

    // 1: cold miss, taken branch allocates (cnt=2)
    run_instr("t1", 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
    // 2: hit predicted taken, correct (cnt 2->3)
    run_instr("t2", 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200);
    // 3: four not-taken: cnt 3->2->1->0->0
    run_instr("t3a", 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h104);
    run_instr("t3b", 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h104);
    run_instr("t3c", 32'h100, 1'b1, 1'b0, 32'h200, 1'b0, 32'h200, 1'b0, 32'h104);
    run_instr("t3d", 32'h100, 1'b1, 1'b0, 32'h200, 1'b0, 32'h200, 1'b0, 32'h104);
    // a wrapped counter would predict taken here; saturated 0 must not (cnt 0->1)
    run_instr("t3e", 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h200, 1'b1, 32'h200);

    // 4: alias 0x140 shares index 0 and overwrites the entry
    run_instr("t4a", 32'h140, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h300);
    run_instr("t4b", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104);
    run_instr("t4c", 32'h140, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'h144);
    run_instr("t4d", 32'h140, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h144);

    // 5: stall D two cycles, then flush E
    run_instr("t5a", 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
    PCF = 32'h100;
    #2;
    check_eq("t5.pred_taken", 32'(PredTakenF), 32'd1);
    tick();
    PCF = Fill; StallD = 1'b1;
    tick();
    FlushE = 1'b1;
    #2;
    check_eq("t5.e_pc_before_flush", RedirectPCE, 32'h104);
    check_eq("t5.no_misp_invalid", 32'(MispredictE), 32'd0);
    tick();
    StallD = 1'b0; FlushE = 1'b0; ValidE = 1'b1;
    #2;
    check_eq("t5.e_cleared_misp", 32'(MispredictE), 32'd0);
    check_eq("t5.e_cleared_redir", RedirectPCE, 32'd4);
    tick();
    BranchE = 1'b1; BranchTakenE = 1'b1; BranchTargetE = 32'h200;
    #2;
    check_eq("t5.d_held_misp", 32'(MispredictE), 32'd0);
    check_eq("t5.d_held_redir", RedirectPCE, 32'h200);
    tick();
    clear_e();

    // 6: same-cycle invalidate and lookup on index 0 (entry cnt=3)
    PCF = 32'h100;
    tick();
    PCF = Fill;
    tick();
    PCF = 32'h100; ValidE = 1'b1;
    #2;
    check_eq("t6.lookup_old_taken", 32'(PredTakenF), 32'd1);
    check_eq("t6.lookup_old_target", PredTargetF, 32'h200);
    check_eq("t6.nonbr_misp", 32'(MispredictE), 32'd1);
    check_eq("t6.nonbr_redir", RedirectPCE, 32'h104);
    tick();
    clear_e();
    #2;
    check_eq("t6.after_inval", 32'(PredTakenF), 32'd0);
    tick();

    // reset asserted while an allocating update is in E
    run_instr("t6b", 32'h208, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 32'h400);
    PCF = 32'h100;
    tick();
    PCF = 32'h208;
    #2;
    check_eq("t6.idx2_hit", 32'(PredTakenF), 32'd1);
    check_eq("t6.idx2_target", PredTargetF, 32'h400);
    tick();
    ValidE = 1'b1; BranchE = 1'b1; BranchTakenE = 1'b1; BranchTargetE = 32'h200;
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6.rst_idx2_miss", 32'(PredTakenF), 32'd0);
    tick();
    clear_e();
    #1;
    check_eq("t6.rst_misp", 32'(MispredictE), 32'd0);
    check_eq("t6.rst_redir", RedirectPCE, 32'd4);
    reset = 1'b0;
    #1;
    check_eq("t6.post_idx2_taken", 32'(PredTakenF), 32'd0);
    check_eq("t6.post_idx2_target", PredTargetF, 32'd0);
    PCF = 32'h100;
    #1;
    check_eq("t6.post_idx0_taken", 32'(PredTakenF), 32'd0);
    check_eq("t6.post_idx0_target", PredTargetF, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
